caravel_sram_scan_ctrl: RTL and testbench

GPIO-driven scan-chain controller for the OpenRAM test chip user area.
- A 112-bit serial register is shifted in from one GPIO pin. Its contents select one of up to 16 SRAM macros and hold both port commands (address, data, csb, web, wmask).
- A global chip-select strobe issues the access. Read data is captured, loaded back into the chain and shifted out on a GPIO pin.

---
 rtl/caravel_sram_scan_ctrl_pkg.sv | 54 +++++
 rtl/caravel_sram_scan_ctrl_if.sv | 44 ++++
 rtl/caravel_sram_scan_ctrl_chain.sv | 33 +++
 rtl/caravel_sram_scan_ctrl.sv | 114 +++++++++++
 tb/tb_caravel_sram_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caravel_sram_scan_ctrl_pkg.sv
// Shared definitions for the OpenRAM test-chip scan controller: chain geometry,
// field positions, reset image and the default macro population masks.
package caravel_sram_scan_ctrl_pkg;

    localparam int CHAIN_W = 112;

    // Field positions inside the serial chain (MSB is shifted out first).
    localparam int SEL_MSB    = 111;
    localparam int SEL_LSB    = 108;
    localparam int ADDR0_MSB  = 107;
    localparam int ADDR0_LSB  = 92;
    localparam int DIN0_MSB   = 91;
    localparam int DIN0_LSB   = 60;
    localparam int CSB0_BIT   = 59;
    localparam int WEB0_BIT   = 58;
    localparam int WMASK0_MSB = 57;
    localparam int WMASK0_LSB = 54;
    localparam int ADDR1_MSB  = 53;
    localparam int ADDR1_LSB  = 38;
    localparam int DIN1_MSB   = 37;
    localparam int DIN1_LSB   = 6;
    localparam int CSB1_BIT   = 5;
    localparam int WEB1_BIT   = 4;
    localparam int WMASK1_MSB = 3;
    localparam int WMASK1_LSB = 0;

    localparam int NUM_SRAMS_DEF = 16;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 32;

    // Slots 0-6 carry dual-port macros, slots 8-10 single-port ones.
    localparam logic [15:0] DUAL_PORT_MASK_DEF   = 16'h007F;
    localparam logic [15:0] SINGLE_PORT_MASK_DEF = 16'h0700;

    // Both chip selects idle (high) out of reset, everything else zero.
    localparam logic [CHAIN_W-1:0] CHAIN_RST =
        (CHAIN_W'(1) << CSB0_BIT) | (CHAIN_W'(1) << CSB1_BIT);

    // Decoded view of the chain, same order as the bit map above.
    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] addr0;
        logic [31:0] din0;
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [15:0] addr1;
        logic [31:0] din1;
        logic        csb1;
        logic        web1;
        logic [3:0]  wmask1;
    } scan_cmd_t;

endpackage

// File: rtl/caravel_sram_scan_ctrl_if.sv
// GPIO scan pins plus the SRAM macro bus of the scan controller.
interface caravel_sram_scan_ctrl_if
    import caravel_sram_scan_ctrl_pkg::*;
#(
    parameter int NUM_SRAMS = NUM_SRAMS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) ();

    logic                          scan_en;
    logic                          sram_load;
    logic                          global_csb;
    logic                          sdi;
    logic                          sdo;
    logic [NUM_SRAMS-1:0]          sram_csb0;
    logic [NUM_SRAMS-1:0]          sram_csb1;
    logic                          sram_web0;
    logic                          sram_web1;
    logic [3:0]                    sram_wmask0;
    logic [3:0]                    sram_wmask1;
    logic [ADDR_W-1:0]             sram_addr0;
    logic [ADDR_W-1:0]             sram_addr1;
    logic [DATA_W-1:0]             sram_din0;
    logic [DATA_W-1:0]             sram_din1;
    logic [NUM_SRAMS*DATA_W-1:0]   sram_dout0;
    logic [NUM_SRAMS*DATA_W-1:0]   sram_dout1;

    // Driver side: GPIO pins and the SRAM read-data return.
    modport master (
        output scan_en, sram_load, global_csb, sdi, sram_dout0, sram_dout1,
        input  sdo, sram_csb0, sram_csb1, sram_web0, sram_web1,
               sram_wmask0, sram_wmask1, sram_addr0, sram_addr1,
               sram_din0, sram_din1
    );

    // Controller side.
    modport slave (
        input  scan_en, sram_load, global_csb, sdi, sram_dout0, sram_dout1,
        output sdo, sram_csb0, sram_csb1, sram_web0, sram_web1,
               sram_wmask0, sram_wmask1, sram_addr0, sram_addr1,
               sram_din0, sram_din1
    );

endinterface

// File: rtl/caravel_sram_scan_ctrl_chain.sv
// 112-bit command/response chain: serial shift from sdi, or parallel reload of
// the two din fields with captured read data. Reload wins over shifting.
module sram_scan_chain
    import caravel_sram_scan_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               shift_en,
    input  logic               load_en,
    input  logic               sdi,
    input  logic               load0,
    input  logic               load1,
    input  logic [DATA_W-1:0]  load0_data,
    input  logic [DATA_W-1:0]  load1_data,
    output logic [CHAIN_W-1:0] chain
);

    // Reload only the din fields of ports that performed a read; every other
    // field keeps its value so the command image comes back unchanged.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            chain <= CHAIN_RST;
        end else if (load_en) begin
            if (load0) chain[DIN0_MSB:DIN0_LSB] <= load0_data;
            if (load1) chain[DIN1_MSB:DIN1_LSB] <= load1_data;
        end else if (shift_en) begin
            chain <= {chain[CHAIN_W-2:0], sdi};
        end
    end

endmodule

// File: rtl/caravel_sram_scan_ctrl.sv
// Scan-chain controller for the OpenRAM test chip: decodes the chain into
// per-macro chip selects on a global strobe, tracks reads, captures the
// selected macro's read data one cycle later and hands it back to the chain.
module caravel_sram_scan_ctrl
    import caravel_sram_scan_ctrl_pkg::*;
#(
    parameter int                   NUM_SRAMS        = NUM_SRAMS_DEF,
    parameter int                   ADDR_W           = ADDR_W_DEF,
    parameter int                   DATA_W           = DATA_W_DEF,
    parameter logic [NUM_SRAMS-1:0] DUAL_PORT_MASK   = DUAL_PORT_MASK_DEF,
    parameter logic [NUM_SRAMS-1:0] SINGLE_PORT_MASK = SINGLE_PORT_MASK_DEF
) (
    input  logic                     clock,
    input  logic                     resetb,
    caravel_sram_scan_ctrl_if.slave  bus
);

    logic [CHAIN_W-1:0]   chain;
    scan_cmd_t            cmd;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic                 access;
    logic                 dual;
    logic                 populated;
    logic [NUM_SRAMS-1:0] csb0_n;
    logic [NUM_SRAMS-1:0] csb1_n;

    logic                 pending;
    logic                 rd0_q;
    logic                 rd1_q;
    logic [3:0]           sel_q;
    logic [DATA_W-1:0]    dout0_q;
    logic [DATA_W-1:0]    dout1_q;

    logic [DATA_W-1:0]    dout0_slot [NUM_SRAMS];
    logic [DATA_W-1:0]    dout1_slot [NUM_SRAMS];

    assign cmd   = scan_cmd_t'(chain);
    assign addr0 = cmd.addr0;
    assign addr1 = cmd.addr1;

    // A strobe during shifting is ignored so a half-loaded command never fires.
    assign access    = !bus.global_csb && !bus.scan_en;
    assign dual      = DUAL_PORT_MASK[cmd.sel];
    assign populated = DUAL_PORT_MASK[cmd.sel] | SINGLE_PORT_MASK[cmd.sel];

    for (genvar g = 0; g < NUM_SRAMS; g++) begin : g_slot
        assign dout0_slot[g] = bus.sram_dout0[g*DATA_W +: DATA_W];
        assign dout1_slot[g] = bus.sram_dout1[g*DATA_W +: DATA_W];
    end

    sram_scan_chain #(
        .DATA_W (DATA_W)
    ) u_chain (
        .clock      (clock),
        .resetb     (resetb),
        .shift_en   (bus.scan_en),
        .load_en    (bus.sram_load),
        .sdi        (bus.sdi),
        .load0      (rd0_q),
        .load1      (rd1_q),
        .load0_data (dout0_q),
        .load1_data (dout1_q),
        .chain      (chain)
    );

    // Route the chain csb fields to the selected macro only; port 1 exists
    // only on dual-port slots and unpopulated slots get no select at all.
    always_comb begin
        csb0_n = '1;
        csb1_n = '1;
        if (access && populated) begin
            csb0_n[cmd.sel] = cmd.csb0;
            if (dual) csb1_n[cmd.sel] = cmd.csb1;
        end
    end

    assign bus.sdo         = chain[CHAIN_W-1];
    assign bus.sram_csb0   = csb0_n;
    assign bus.sram_csb1   = csb1_n;
    assign bus.sram_web0   = cmd.web0;
    assign bus.sram_web1   = cmd.web1;
    assign bus.sram_wmask0 = cmd.wmask0;
    assign bus.sram_wmask1 = cmd.wmask1;
    assign bus.sram_addr0  = addr0;
    assign bus.sram_addr1  = addr1;
    assign bus.sram_din0   = cmd.din0;
    assign bus.sram_din1   = cmd.din1;

    // Remember which ports read on an access, then capture the macro output
    // on the next edge, once the SRAM has driven its registered read data.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pending <= 1'b0;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            sel_q   <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            if (pending) begin
                if (rd0_q) dout0_q <= dout0_slot[sel_q];
                if (rd1_q) dout1_q <= dout1_slot[sel_q];
            end
            pending <= access;
            if (access) begin
                rd0_q <= !cmd.csb0 && cmd.web0;
                rd1_q <= !cmd.csb1 && cmd.web1 && dual;
                sel_q <= cmd.sel;
            end
        end
    end

endmodule

// File: tb/tb_caravel_sram_scan_ctrl.sv
// Bench for caravel_sram_scan_ctrl: behavioural SRAM macros on the bus,
// directed scan sequences, expected images queued by the stimulus and
// checked by an independent monitor process.
module tb_caravel_sram_scan_ctrl;
    import caravel_sram_scan_ctrl_pkg::*;

    logic clock;
    logic resetb;
    logic model_clr;
    logic unload_active;

    caravel_sram_scan_ctrl_if #(.NUM_SRAMS(16), .ADDR_W(16), .DATA_W(32)) bus ();

    caravel_sram_scan_ctrl dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural macros: port 0 read/write, port 1 read-only, registered read.
    logic [31:0] mem [16][4];
    logic [31:0] d0 [16];
    logic [31:0] d1 [16];

    always @(posedge clock) begin
        for (int i = 0; i < 16; i++) begin
            if (model_clr) begin
                d0[i] <= 32'hA5A5_0000 | i;
                d1[i] <= 32'h5A5A_0000 | i;
                for (int a = 0; a < 4; a++) mem[i][a] <= '0;
            end else begin
                if (!bus.sram_csb0[i]) begin
                    if (!bus.sram_web0) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.sram_wmask0[b])
                                mem[i][bus.sram_addr0[1:0]][8*b +: 8] <= bus.sram_din0[8*b +: 8];
                    end else begin
                        d0[i] <= mem[i][bus.sram_addr0[1:0]];
                    end
                end
                if (!bus.sram_csb1[i] && bus.sram_web1)
                    d1[i] <= mem[i][bus.sram_addr1[1:0]];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_dout
        assign bus.sram_dout0[g*32 +: 32] = d0[g];
        assign bus.sram_dout1[g*32 +: 32] = d1[g];
    end

    typedef struct {
        string       name;
        logic [15:0] csb0;
        logic [15:0] csb1;
        logic        sdo;
    } snap_t;

    typedef struct {
        string        name;
        logic [111:0] img;
    } word_t;

    snap_t snap_q [$];
    word_t word_q [$];
    int    chk_cnt  = 0;
    int    pass_cnt = 0;

    function automatic logic [111:0] img(
        input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] dd0,
        input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] dd1,
        input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, dd0, c0, w0, m0, a1, dd1, c1, w1, m1};
    endfunction

    // Monitor: compares pin snapshots and reassembles shifted-out words.
    initial begin : monitor
        logic [111:0] acc;
        int           nbits;
        snap_t        s;
        word_t        w;
        acc   = '0;
        nbits = 0;
        forever begin
            @(negedge clock);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk_cnt++;
                if (bus.sram_csb0 === s.csb0 && bus.sram_csb1 === s.csb1 && bus.sdo === s.sdo)
                    pass_cnt++;
                else
                    $display("FAIL %s: got csb0=%h csb1=%h sdo=%b, want csb0=%h csb1=%h sdo=%b",
                             s.name, bus.sram_csb0, bus.sram_csb1, bus.sdo, s.csb0, s.csb1, s.sdo);
            end
            if (unload_active) begin
                acc = {acc[110:0], bus.sdo};
                nbits++;
                if (nbits == 112) begin
                    nbits = 0;
                    chk_cnt++;
                    if (word_q.size() == 0) begin
                        $display("FAIL unexpected_word: got %h, want none", acc);
                    end else begin
                        w = word_q.pop_front();
                        if (acc === w.img) pass_cnt++;
                        else $display("FAIL %s: got %h, want %h", w.name, acc, w.img);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, got %0d/%0d checks", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic shift_in(input logic [111:0] v);
        bus.scan_en = 1'b1;
        for (int i = 111; i >= 0; i--) begin
            bus.sdi = v[i];
            tick();
        end
        bus.scan_en = 1'b0;
        bus.sdi     = 1'b0;
    endtask

    // Strobe cycle followed by the capture cycle.
    task automatic access();
        bus.global_csb = 1'b0;
        tick();
        bus.global_csb = 1'b1;
        tick();
    endtask

    task automatic load();
        bus.sram_load = 1'b1;
        tick();
        bus.sram_load = 1'b0;
    endtask

    task automatic unload(input string name, input logic [111:0] exp);
        word_t w;
        w.name = name;
        w.img  = exp;
        word_q.push_back(w);
        bus.scan_en   = 1'b1;
        unload_active = 1'b1;
        repeat (112) tick();
        bus.scan_en   = 1'b0;
        unload_active = 1'b0;
    endtask

    task automatic snap(input string name, input logic [15:0] c0, input logic [15:0] c1, input logic o);
        snap_t s;
        s.name = name;
        s.csb0 = c0;
        s.csb1 = c1;
        s.sdo  = o;
        snap_q.push_back(s);
    endtask

    // Decode check: shift a command, strobe it and look at the selects.
    task automatic decode(input string name, input logic [111:0] v,
                          input logic [15:0] c0, input logic [15:0] c1, input logic o);
        shift_in(v);
        bus.global_csb = 1'b0;
        snap(name, c0, c1, o);
        tick();
        bus.global_csb = 1'b1;
        tick();
    endtask

    initial begin : stimulus
        resetb         = 1'b0;
        model_clr      = 1'b1;
        unload_active  = 1'b0;
        bus.scan_en    = 1'b0;
        bus.sram_load  = 1'b0;
        bus.global_csb = 1'b0;
        bus.sdi        = 1'b0;
        #2;
        snap("reset_state", 16'hFFFF, 16'hFFFF, 1'b0);
        repeat (3) tick();
        resetb         = 1'b1;
        model_clr      = 1'b0;
        bus.global_csb = 1'b1;
        tick();

        // Dual-port slots: two writes, then a read on both ports at once.
        for (int s = 0; s < 7; s++) begin
            shift_in(img(4'(s), 16'd1, 32'(s), 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
            access();
            shift_in(img(4'(s), 16'd2, 32'(s << 3), 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
            access();
            shift_in(img(4'(s), 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd2, 32'd0, 1'b0, 1'b1, 4'hF));
            access();
            load();
            unload($sformatf("dual_read_sel%0d", s),
                   img(4'(s), 16'd1, 32'(s), 1'b0, 1'b1, 4'hF, 16'd2, 32'(s << 3), 1'b0, 1'b1, 4'hF));
        end

        // Load and shift on the same edge: only the load happens.
        shift_in(img(4'h9, 16'hABCD, 32'h1111_1111, 1'b1, 1'b0, 4'h3,
                     16'h1234, 32'h2222_2222, 1'b0, 1'b1, 4'hC));
        bus.scan_en   = 1'b1;
        bus.sram_load = 1'b1;
        bus.sdi       = 1'b1;
        tick();
        bus.scan_en   = 1'b0;
        bus.sram_load = 1'b0;
        bus.sdi       = 1'b0;
        unload("load_priority", img(4'h9, 16'hABCD, 32'd6, 1'b1, 1'b0, 4'h3,
                                    16'h1234, 32'd48, 1'b0, 1'b1, 4'hC));

        // Single-port slots: port 1 request must not reach the macro.
        for (int s = 8; s <= 10; s++) begin
            shift_in(img(4'(s), 16'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
            access();
            shift_in(img(4'(s), 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF));
            access();
            load();
            unload($sformatf("single_read_sel%0d", s),
                   img(4'(s), 16'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF));
        end

        // Chip-select decode.
        decode("decode_sel5_p0", img(4'd5, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
               16'hFFDF, 16'hFFFF, 1'b0);
        decode("decode_sel5_p0p1", img(4'd5, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF),
               16'hFFDF, 16'hFFDF, 1'b0);
        shift_in(img(4'd5, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF));
        bus.global_csb = 1'b0;
        bus.scan_en    = 1'b1;
        snap("strobe_while_shifting", 16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        bus.global_csb = 1'b1;
        bus.scan_en    = 1'b0;
        tick();
        decode("decode_sel8_single", img(4'd8, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF),
               16'hFEFF, 16'hFFFF, 1'b1);
        decode("decode_sel12_empty", img(4'd12, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF),
               16'hFFFF, 16'hFFFF, 1'b1);

        // Asynchronous reset in the middle of a scan.
        bus.scan_en = 1'b1;
        bus.sdi     = 1'b1;
        repeat (50) tick();
        bus.scan_en    = 1'b0;
        bus.sdi        = 1'b0;
        resetb         = 1'b0;
        bus.global_csb = 1'b0;
        snap("midscan_reset_pins", 16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        bus.global_csb = 1'b1;
        resetb         = 1'b1;
        tick();
        unload("midscan_reset_chain", img(4'd0, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0,
                                          16'd0, 32'd0, 1'b1, 1'b0, 4'h0));
        shift_in(img(4'd3, 16'h0042, 32'hCAFE_F00D, 1'b0, 1'b1, 4'hF,
                     16'h0043, 32'h0BAD_BEEF, 1'b0, 1'b1, 4'hF));
        load();
        unload("post_reset_load", img(4'd3, 16'h0042, 32'hCAFE_F00D, 1'b0, 1'b1, 4'hF,
                                      16'h0043, 32'h0BAD_BEEF, 1'b0, 1'b1, 4'hF));

        repeat (3) tick();
        chk_cnt++;
        if (word_q.size() == 0 && snap_q.size() == 0)
            pass_cnt++;
        else
            $display("FAIL drain: got %0d words and %0d snapshots unchecked, want 0 and 0",
                     word_q.size(), snap_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
